// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned AW_DEF     = 13;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned TO_CYC_DEF = 15;
  localparam int unsigned CntW       = 8;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  typedef enum logic [1:0] {StIdle, StAddr, StWait, StResp} state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus: request/address/data in, ack/err/rdata back.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (output req, wr, addr, wdata, input ack, err, rdata);
  modport slave  (input req, wr, addr, wdata, output ack, err, rdata);

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Two-way grant selection. With ARB_RR_EN defined a priority pointer alternates
// on every grant; otherwise the CPU has fixed priority.
module arb_pick
  import mem_arbiter_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic clk_i,
  input  logic rst_ni,
  input  logic grant_i,
`endif
  input  logic c_req_i,
  input  logic h_req_i,
  output logic host_o
);

`ifdef ARB_RR_EN
  logic prio_q, prio_d;

  // The requester that did not just win holds priority for the next tie.
  always_comb begin
    host_o = h_req_i & (~c_req_i | (prio_q == OWN_HOST));
    prio_d = prio_q;
    if (grant_i) prio_d = host_o ? OWN_CPU : OWN_HOST;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prio_q <= OWN_CPU;
    else         prio_q <= prio_d;
  end
`else
  assign host_o = h_req_i & ~c_req_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and host requesters onto one memory port with a wait timeout.
// Define ARB_RR_EN for round-robin arbitration instead of fixed CPU priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_arbiter_if.slave  c_if,
  mem_arbiter_if.slave  h_if,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_rd_o,
  output logic          mem_wr_o,
  input  logic          mem_ready_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o,
  output logic          owner_o
);

  state_e          state_q, state_d;
  logic            owner_q, owner_d, wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   c_rdata_q, h_rdata_q, resp_rdata;
  logic            c_err_q, h_err_q;
  logic            resp_load, resp_err, resp_rd_load;
  logic            any_req, pick_host;

  assign any_req = c_if.req | h_if.req;

  arb_pick u_arb_pick (
`ifdef ARB_RR_EN
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .grant_i ((state_q == StIdle) && any_req),
`endif
    .c_req_i (c_if.req),
    .h_req_i (h_if.req),
    .host_o  (pick_host)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_load    = 1'b0;
    resp_err     = 1'b0;
    resp_rd_load = 1'b0;
    resp_rdata   = '0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = pick_host ? OWN_HOST : OWN_CPU;
          wr_d    = pick_host ? h_if.wr    : c_if.wr;
          addr_d  = pick_host ? h_if.addr  : c_if.addr;
          wdata_d = pick_host ? h_if.wdata : c_if.wdata;
          state_d = StAddr;
        end
      end
      // Ready is honoured in the strobe cycle as well as while waiting.
      StAddr, StWait: begin
        if (mem_ready_i) begin
          resp_load    = 1'b1;
          resp_rd_load = ~wr_q;
          resp_rdata   = mem_rdata_i;
          state_d      = StResp;
        end else if (state_q == StAddr) begin
          cnt_d   = '0;
          state_d = StWait;
        end else if (cnt_q == CntW'(TO_CYC - 1)) begin
          resp_load    = 1'b1;
          resp_err     = 1'b1;
          resp_rd_load = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      owner_q   <= OWN_CPU;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
      c_err_q   <= 1'b0;
      h_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      if (resp_load && (owner_q == OWN_CPU)) begin
        c_err_q <= resp_err;
        if (resp_rd_load) c_rdata_q <= resp_rdata;
      end
      if (resp_load && (owner_q == OWN_HOST)) begin
        h_err_q <= resp_err;
        if (resp_rd_load) h_rdata_q <= resp_rdata;
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_rd_o    = (state_q == StAddr) & ~wr_q;
  assign mem_wr_o    = (state_q == StAddr) &  wr_q;
  assign busy_o      = (state_q != StIdle);
  assign owner_o     = owner_q;

  assign c_if.ack   = (state_q == StResp) & (owner_q == OWN_CPU);
  assign h_if.ack   = (state_q == StResp) & (owner_q == OWN_HOST);
  assign c_if.err   = c_err_q;
  assign h_if.err   = h_err_q;
  assign c_if.rdata = c_rdata_q;
  assign h_if.rdata = h_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected completions plus a
// latency-programmable memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, busy, owner;
  logic        mem_ready = 1'b0;
  logic [7:0]  rd_val = 8'h00;

  mem_arbiter_if #(.AW(13), .DW(8)) c_if ();
  mem_arbiter_if #(.AW(13), .DW(8)) h_if ();

  mem_arbiter #(.AW(13), .DW(8), .TO_CYC(15)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .c_if        (c_if),
    .h_if        (h_if),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .mem_ready_i (mem_ready),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy),
    .owner_o     (owner)
  );

  always #5 clk = ~clk;
  assign mem_rdata = rd_val;

  typedef struct {
    bit         own;
    bit         err;
    bit         chk_rd;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0, n_fail = 0;
  int mem_lat = 0;  // -1: never ready
  int wcnt = -1, rd_cyc = 0, wr_cyc = 0, both_hi = 0, c_ack_cnt = 0, h_ack_cnt = 0;
  logic [12:0] cap_addr = '0;
  logic [7:0]  cap_wdata = '0;

  // Memory model and monitors, all sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_rd && mem_wr) both_hi++;
    if (c_if.ack) c_ack_cnt++;
    if (h_if.ack) h_ack_cnt++;
    if (!rst_n) begin
      mem_ready = 1'b0;
      wcnt = -1;
    end else if (mem_rd || mem_wr) begin
      if (mem_rd) rd_cyc++;
      if (mem_wr) wr_cyc++;
      cap_addr  = mem_addr;
      cap_wdata = mem_wdata;
      if (mem_lat == 0) begin
        mem_ready = 1'b1;
        wcnt = -1;
      end else begin
        mem_ready = 1'b0;
        wcnt = 1;
      end
    end else if (wcnt > 0) begin
      if (wcnt == mem_lat) begin
        mem_ready = 1'b1;
        wcnt = -1;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
    end
  end

  // Waits for either ack; cyc counts the cycle the request was driven as 1.
  task automatic wait_ack(input int budget, output int cyc, output bit own, output bit ok);
    ok = 1'b0;
    own = 1'b0;
    cyc = 1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      cyc++;
      if (c_if.ack || h_if.ack) begin
        ok = 1'b1;
        own = h_if.ack;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, mem_rd, mem_wr, owner, c_if.ack, h_if.ack} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/rd/wr/owner/cack/hack=%b, want 000000",
               {busy, mem_rd, mem_wr, owner, c_if.ack, h_if.ack});
    end
    n_tests++;
    if (mem_addr !== 13'h0 || mem_wdata !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h wdata=%h, want 0/0", mem_addr, mem_wdata);
    end
    n_tests++;
    if ({c_if.err, h_if.err, c_if.rdata, h_if.rdata} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_resp: cerr=%b herr=%b crd=%h hrd=%h, want 0", c_if.err, h_if.err,
               c_if.rdata, h_if.rdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cpu_read();
    int cyc, rd0;
    bit own, ok;
    exp_t e;
    mem_lat = 1;
    rd_val = 8'hA5;
    rd0 = rd_cyc;
    c_if.wr = 1'b0;
    c_if.addr = 13'h0123;
    c_if.req = 1'b1;
    sb.push_back('{own: OWN_CPU, err: 1'b0, chk_rd: 1'b1, rdata: 8'hA5});
    wait_ack(40, cyc, own, ok);
    c_if.req = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc != 4) begin
      n_fail++;
      $display("FAIL cpu_read_latency: ack seen=%0b at cycle %0d, want cycle 4", ok, cyc);
    end
    n_tests++;
    if (own !== e.own || c_if.err !== e.err || c_if.rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL cpu_read_data: own=%b err=%b rdata=%h, want %b %b %h", own, c_if.err,
               c_if.rdata, e.own, e.err, e.rdata);
    end
    n_tests++;
    if (rd_cyc - rd0 != 1 || cap_addr !== 13'h0123) begin
      n_fail++;
      $display("FAIL cpu_read_strobe: rd cycles=%0d addr=%h, want 1 and 0123", rd_cyc - rd0,
               cap_addr);
    end
    @(negedge clk);
    n_tests++;
    if (c_if.ack !== 1'b0 || c_if.rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL cpu_read_pulse: ack=%b rdata=%h after RESP, want 0 and a5", c_if.ack,
               c_if.rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_host_write();
    int cyc, wr0, c0;
    bit own, ok;
    exp_t e;
    mem_lat = 0;
    wr0 = wr_cyc;
    c0 = c_ack_cnt;
    h_if.wr = 1'b1;
    h_if.addr = 13'h1FFF;
    h_if.wdata = 8'h3C;
    h_if.req = 1'b1;
    sb.push_back('{own: OWN_HOST, err: 1'b0, chk_rd: 1'b0, rdata: 8'h00});
    wait_ack(40, cyc, own, ok);
    h_if.req = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc != 3 || own !== e.own || h_if.err !== e.err) begin
      n_fail++;
      $display("FAIL host_write_ack: seen=%0b cycle=%0d own=%b err=%b, want 1 3 %b %b", ok, cyc,
               own, h_if.err, e.own, e.err);
    end
    n_tests++;
    if (wr_cyc - wr0 != 1 || cap_addr !== 13'h1FFF || cap_wdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL host_write_strobe: wr cycles=%0d addr=%h data=%h, want 1 1fff 3c",
               wr_cyc - wr0, cap_addr, cap_wdata);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (c_ack_cnt != c0) begin
      n_fail++;
      $display("FAIL host_write_cack: c_ack pulses=%0d, want 0", c_ack_cnt - c0);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit own, ok;
    exp_t e;
    bit exp_own[4];
`ifdef ARB_RR_EN
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    mem_lat = 0;
    rd_val = 8'h5A;
    c_if.wr = 1'b0;
    h_if.wr = 1'b0;
    c_if.addr = 13'h0010;
    h_if.addr = 13'h0020;
    for (int k = 0; k < 4; k++)
      sb.push_back('{own: exp_own[k], err: 1'b0, chk_rd: 1'b1, rdata: 8'h5A});
    c_if.req = 1'b1;
    h_if.req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, cyc, own, ok);
      if (k == 3) begin
        c_if.req = 1'b0;
        h_if.req = 1'b0;
      end
      e = sb.pop_front();
      n_tests++;
      if (!ok || own !== e.own || (c_if.ack && h_if.ack) ||
          (own ? h_if.rdata : c_if.rdata) !== e.rdata) begin
        n_fail++;
        $display("FAIL arb_grant%0d: seen=%0b own=%b both=%b, want own %b", k, ok, own,
                 c_if.ack && h_if.ack, e.own);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc;
    bit own, ok;
    exp_t e;
    mem_lat = -1;
    rd_val = 8'hFF;
    c_if.wr = 1'b0;
    c_if.addr = 13'h0042;
    c_if.req = 1'b1;
    sb.push_back('{own: OWN_CPU, err: 1'b1, chk_rd: 1'b1, rdata: 8'h00});
    wait_ack(40, cyc, own, ok);
    c_if.req = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc != 18 || own !== e.own || c_if.err !== e.err || c_if.rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL timeout: seen=%0b cycle=%0d err=%b rdata=%h, want cycle 18 err 1 rdata 00",
               ok, cyc, c_if.err, c_if.rdata);
    end
    repeat (2) @(negedge clk);
    mem_lat = 2;
    rd_val = 8'h77;
    c_if.req = 1'b1;
    sb.push_back('{own: OWN_CPU, err: 1'b0, chk_rd: 1'b1, rdata: 8'h77});
    wait_ack(40, cyc, own, ok);
    c_if.req = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc != 5 || c_if.err !== e.err || c_if.rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL timeout_recover: seen=%0b cycle=%0d err=%b rdata=%h, want 5 0 77", ok,
               cyc, c_if.err, c_if.rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc, c0;
    bit own, ok;
    exp_t e;
    mem_lat = -1;
    c0 = c_ack_cnt;
    c_if.wr = 1'b0;
    c_if.addr = 13'h00AA;
    c_if.req = 1'b1;
    @(negedge clk);
    h_if.wr = 1'b0;
    h_if.addr = 13'h00BB;
    h_if.req = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || owner !== OWN_CPU) begin
      n_fail++;
      $display("FAIL rst_mid_pre: busy=%b owner=%b, want 1 0", busy, owner);
    end
    rst_n = 1'b0;
    c_if.req = 1'b0;
    #1;
    n_tests++;
    if ({busy, mem_rd, mem_wr, c_if.ack, h_if.ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: busy/rd/wr/cack/hack=%b, want 00000",
               {busy, mem_rd, mem_wr, c_if.ack, h_if.ack});
    end
    repeat (2) @(negedge clk);
    mem_lat = 0;
    rd_val = 8'h99;
    rst_n = 1'b1;
    sb.push_back('{own: OWN_HOST, err: 1'b0, chk_rd: 1'b1, rdata: 8'h99});
    wait_ack(20, cyc, own, ok);
    h_if.req = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (!ok || cyc != 3 || own !== e.own || h_if.rdata !== e.rdata || h_if.err !== e.err) begin
      n_fail++;
      $display("FAIL rst_mid_host: seen=%0b cycle=%0d own=%b rdata=%h, want 1 3 1 99", ok, cyc,
               own, h_if.rdata);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (c_ack_cnt != c0) begin
      n_fail++;
      $display("FAIL rst_mid_noack: c_ack pulses=%0d, want 0", c_ack_cnt - c0);
    end
  endtask

  task automatic test_drop_req();
    int cyc, c0;
    bit own, ok;
    exp_t e;
    mem_lat = 3;
    rd_val = 8'h3E;
    c0 = c_ack_cnt;
    c_if.wr = 1'b0;
    c_if.addr = 13'h0555;
    c_if.req = 1'b1;
    sb.push_back('{own: OWN_CPU, err: 1'b0, chk_rd: 1'b1, rdata: 8'h3E});
    repeat (3) @(negedge clk);
    c_if.req = 1'b0;
    wait_ack(20, cyc, own, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || own !== e.own || c_if.rdata !== e.rdata || c_if.err !== e.err) begin
      n_fail++;
      $display("FAIL drop_req_ack: seen=%0b own=%b rdata=%h, want 1 0 3e", ok, own, c_if.rdata);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (c_ack_cnt - c0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_req_once: c_ack pulses=%0d busy=%b, want 1 0", c_ack_cnt - c0, busy);
    end
  endtask

  initial begin
    c_if.req = 1'b0;  c_if.wr = 1'b0;  c_if.addr = '0;  c_if.wdata = '0;
    h_if.req = 1'b0;  h_if.wr = 1'b0;  h_if.addr = '0;  h_if.wdata = '0;
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_host_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_drop_req();
    n_tests++;
    if (both_hi != 0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL strobe_excl: both-high cycles=%0d leftover=%0d, want 0 0", both_hi,
               sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion before 100us");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 13, address width; DW, 8, data width; TO_CYC, 15, memory-wait timeout in cycles (range 1..255).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 c_req  in  1  CPU requester access request, held until c_ack.
REQ-005 c_wr  in  1  CPU write (1) / read (0).
REQ-006 c_addr  in  AW, and c_wdata  in  DW: CPU address and write data.
REQ-007 c_ack  out  1, c_err  out  1, c_rdata  out  DW: CPU completion pulse, timeout flag, read data.
REQ-008 h_req, h_wr, h_addr, h_wdata, h_ack, h_err, h_rdata: host/loader requester, same widths and meaning as the CPU set.
REQ-009 mem_addr  out  AW, and mem_wdata  out  DW: shared memory address and write data.
REQ-010 mem_rd  out  1, and mem_wr  out  1: memory strobes.
REQ-011 mem_ready  in  1, and mem_rdata  in  DW: memory completion and read data.
REQ-012 busy  out  1, and owner  out  1: transaction in progress; current grant (0 = CPU, 1 = host).

Function
REQ-013 FSM states SHALL be IDLE, ADDR, WAIT, RESP.
REQ-014 IDLE: if any req is high, latch the winner's addr, wdata, wr and owner, then go to ADDR; otherwise stay in IDLE.
REQ-015 ADDR: assert mem_rd (if read) or mem_wr (if write) for exactly this one cycle with latched mem_addr/mem_wdata, then go to WAIT.
REQ-016 WAIT: hold mem_addr/mem_wdata stable, strobes low; on mem_ready go to RESP with err=0, capturing mem_rdata on reads.
REQ-017 WAIT: mem_ready high in the ADDR cycle SHALL also be honoured (ADDR -> RESP directly).
REQ-018 Timeout: a wait counter SHALL count cycles in WAIT; upon reaching TO_CYC without mem_ready, go to RESP with err=1 and rdata=0.
REQ-019 RESP: pulse the owner's ack high for exactly one cycle, with rdata/err valid in that cycle; the other requester's ack stays 0; then go to IDLE.
REQ-020 Minimum latency SHALL be 3 cycles from req sampled in IDLE to ack high (IDLE, ADDR, RESP with immediate mem_ready).
REQ-021 Requester inputs SHALL be ignored after latching; deasserting req mid-transaction SHALL NOT abort it, and ack is still pulsed.
REQ-022 A requester still holding req in the ack cycle SHALL be treated as a new request at the next IDLE.
REQ-023 c_rdata/h_rdata and c_err/h_err SHALL hold their last values until that requester's next RESP.
REQ-024 busy SHALL be 1 in ADDR, WAIT and RESP; owner SHALL be valid whenever busy=1.
REQ-025 mem_rd and mem_wr SHALL never both be high.

Reset
REQ-026 On rst low: state=IDLE, all acks/errs/strobes=0, mem_addr=0, mem_wdata=0, rdata registers=0, owner=0, busy=0, wait counter=0, round-robin pointer=CPU.
REQ-027 Reset asserted mid-transaction SHALL abort it immediately with no ack; strobes drop asynchronously.

Configuration
REQ-028 Macro ARB_RR_EN defined: round-robin arbitration. On simultaneous requests the requester not granted last wins; the pointer updates on each grant.
REQ-029 ARB_RR_EN undefined: fixed priority, CPU always wins simultaneous requests; no pointer register is built.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration, the OWN_CPU/OWN_HOST constants and the default AW/DW/TO_CYC values.
REQ-031 One sub-module, arb_pick (2-way grant selection including the round-robin pointer), is natural; the FSM and datapath stay in mem_arbiter.

Verification
REQ-032 CPU read 0x0123, mem_ready 1 cycle after ADDR, mem_rdata=0xA5 -> c_ack pulse at cycle 4, c_rdata=0xA5, c_err=0, mem_rd high exactly 1 cycle.
REQ-033 Host write 0x1FFF data 0x3C, immediate mem_ready -> mem_wr with addr 0x1FFF/data 0x3C for 1 cycle, h_ack at cycle 3, c_ack stays 0.
REQ-034 c_req and h_req held continuously -> ARB_RR_EN: grants alternate CPU, host, CPU, host; without the macro: CPU only.
REQ-035 CPU read, mem_ready never asserted, TO_CYC=15 -> c_ack with c_err=1 and c_rdata=0 after 15 WAIT cycles; next request is serviced normally.
REQ-036 rst low during WAIT -> busy=0 and strobes 0 immediately, no ack; after release, a pending h_req completes normally.
REQ-037 c_req dropped during WAIT -> transaction completes and c_ack still pulses once.
